// File: rtl/lcd_stream_ctrl.sv
// lcd_stream_ctrl: HD44780 8-bit write-only driver with power-up init and a {rs,data} byte FIFO
module lcd_stream_ctrl #(
    parameter int         EN_CYC     = 50,
    parameter int         SHORT_CYC  = 2500,
    parameter int         LONG_CYC   = 100000,
    parameter int         PWRUP_CYC  = 1000000,
    parameter int         FIFO_DEPTH = 4,
    parameter bit         TWO_LINE   = 1'b1,
    parameter logic [7:0] DISP_CMD   = 8'h0E
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int M1 = PWRUP_CYC > LONG_CYC ? PWRUP_CYC : LONG_CYC;
    localparam int M2 = SHORT_CYC > EN_CYC ? SHORT_CYC : EN_CYC;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
    localparam logic [7:0] FSET = TWO_LINE ? 8'h38 : 8'h30;

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, SETTLE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, push, pop, is_long;
    logic [CW-1:0]   settle_end;
    logic [7:0]      next_init;

    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign pop        = state == IDLE && init_done && !empty;
    assign busy       = state != IDLE || !empty;
    assign lcd_rw     = 1'b0;
    // clear/home (0x01-0x03) need the long settle; decided from the byte already on the bus
    assign is_long    = !lcd_rs && lcd_data[7:2] == 6'd0;
    assign settle_end = is_long ? CW'(LONG_CYC - 1) : CW'(SHORT_CYC - 1);
    assign next_init  = idx == 3'd0 ? FSET : idx == 3'd1 ? DISP_CMD : idx == 3'd2 ? 8'h01 : 8'h06;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= {in_rs, in_data};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= PWRUP;
            cnt       <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
        end else begin
            case (state)
                PWRUP:
                    if (cnt == CW'(PWRUP_CYC - 1)) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        idx      <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= FSET;
                    end else cnt <= cnt + CW'(1);
                IDLE:
                    if (pop) begin
                        state              <= SETUP;
                        cnt                <= '0;
                        {lcd_rs, lcd_data} <= mem[rd_ptr[AW-1:0]];
                    end
                SETUP: begin
                    state  <= PULSE;
                    cnt    <= '0;
                    lcd_en <= 1'b1;
                end
                PULSE:
                    if (cnt == CW'(EN_CYC - 1)) begin
                        state  <= SETTLE;
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                    end else cnt <= cnt + CW'(1);
                SETTLE:
                    if (cnt == settle_end) begin
                        cnt <= '0;
                        if (init_done) state <= IDLE;
                        else if (idx < 3'd4) begin
                            state    <= SETUP;
                            idx      <= idx + 3'd1;
                            lcd_data <= next_init;
                        end else begin
                            state     <= IDLE;
                            init_done <= 1'b1;
                        end
                    end else cnt <= cnt + CW'(1);
                default: state <= PWRUP;
            endcase
        end
endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// tb_lcd_stream_ctrl: directed checks of init sequence, stream bytes, settle selection, FIFO limits and reset abort
module tb_lcd_stream_ctrl;
    localparam int EN = 2, SHORT = 4, LONG = 10, PWRUP = 20;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, init_done, busy, lcd_en, lcd_rw, lcd_rs;
    logic [7:0] lcd_data;
    logic in_ready2, init_done2, busy2, lcd_en2, lcd_rw2, lcd_rs2;
    logic [7:0] lcd_data2;
    int errors = 0, checks = 0;

    lcd_stream_ctrl #(.EN_CYC(EN), .SHORT_CYC(SHORT), .LONG_CYC(LONG), .PWRUP_CYC(PWRUP),
                      .FIFO_DEPTH(4), .TWO_LINE(1'b1), .DISP_CMD(8'h0E)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
        .in_data(in_data), .init_done(init_done), .busy(busy), .lcd_en(lcd_en),
        .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_data(lcd_data));

    // Single-line variant, never fed; runs in lockstep with dut through every init
    lcd_stream_ctrl #(.EN_CYC(EN), .SHORT_CYC(SHORT), .LONG_CYC(LONG), .PWRUP_CYC(PWRUP),
                      .FIFO_DEPTH(4), .TWO_LINE(1'b0), .DISP_CMD(8'h0E)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(1'b0), .in_ready(in_ready2), .in_rs(1'b0),
        .in_data(8'h00), .init_done(init_done2), .busy(busy2), .lcd_en(lcd_en2),
        .lcd_rw(lcd_rw2), .lcd_rs(lcd_rs2), .lcd_data(lcd_data2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] d);
        in_rs = rs; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // low = en-low negedges before the rise; returns on the first en-low negedge after the pulse
    task automatic wait_pulse(output int low, output int high, output logic rs, output logic [7:0] d,
                              output logic prs, output logic [7:0] pd, output logic [7:0] d2);
        low = 0; prs = lcd_rs; pd = lcd_data;
        while (lcd_en !== 1'b1 && low < 300) begin
            prs = lcd_rs; pd = lcd_data;
            @(negedge clk);
            if (lcd_en !== 1'b1) low++;
        end
        rs = lcd_rs; d = lcd_data; d2 = lcd_data2; high = 0;
        while (lcd_en === 1'b1 && high < 300) begin
            high++;
            @(negedge clk);
        end
    endtask

    task automatic busy_run(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_init(input int exp_pre);
        logic [7:0] e1 [5];
        logic [7:0] e2 [5];
        int low, high, n;
        logic rs, prs;
        logic [7:0] d, pd, d2;
        e1 = '{8'h38, 8'h38, 8'h0E, 8'h01, 8'h06};
        e2 = '{8'h30, 8'h30, 8'h0E, 8'h01, 8'h06};
        for (int i = 0; i < 5; i++) begin
            wait_pulse(low, high, rs, d, prs, pd, d2);
            if (i == 0) chk("pwrup_wait", low, exp_pre);
            else chk("init_settle", low, i == 4 ? LONG : SHORT);
            chk("init_data", d, e1[i]);
            chk("init_rs", rs, 0);
            chk("init_en_width", high, EN);
            chk("init_data_1line", d2, e2[i]);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("last_settle", n, SHORT);
        chk("init_done", init_done, 1);
    endtask

    initial begin
        int low, high, n;
        logic rs, prs;
        logic [7:0] d, pd, d2;
        @(negedge clk);
        chk("rst_en", lcd_en, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        check_init(PWRUP);
        chk("idle_busy", busy, 0);

        push_byte(1'b1, 8'h41);
        wait_pulse(low, high, rs, d, prs, pd, d2);
        chk("t2_setup_rs", prs, 1);
        chk("t2_setup_data", pd, 8'h41);
        chk("t2_rs", rs, 1);
        chk("t2_data", d, 8'h41);
        chk("t2_en_width", high, EN);
        busy_run(n);
        chk("t2_busy_tail", n, SHORT);
        chk("t2_en_idle", lcd_en, 0);

        push_byte(1'b0, 8'h02);
        push_byte(1'b1, 8'h42);
        wait_pulse(low, high, rs, d, prs, pd, d2);
        chk("t4_cmd_data", d, 8'h02);
        chk("t4_cmd_rs", rs, 0);
        wait_pulse(low, high, rs, d, prs, pd, d2);
        // remaining long settle plus the IDLE pop cycle and the SETUP cycle
        chk("t4_long_gap", low, LONG - 1 + 2);
        chk("t4_chr_data", d, 8'h42);
        chk("t4_chr_rs", rs, 1);
        busy_run(n);
        chk("t4_short_tail", n, SHORT);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_byte(1'b1, 8'h77);
        n = 0;
        while (lcd_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_pulse", lcd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_en", lcd_en, 0);
        chk("t5_data", lcd_data, 0);
        chk("t5_rs", lcd_rs, 0);
        chk("t5_init_done", init_done, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check_init(PWRUP);
        chk("t5_fifo_cleared", busy, 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t3_in_ready", in_ready, i < 4);
            in_rs = 1'b1; in_data = 8'h50 + 8'(i); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_init(PWRUP - 6);
        for (int j = 0; j < 4; j++) begin
            wait_pulse(low, high, rs, d, prs, pd, d2);
            chk("t3_order", d, 8'h50 + 8'(j));
            chk("t3_rs", rs, 1);
            chk("t3_en_width", high, EN);
        end
        busy_run(n);
        chk("t3_tail", n, SHORT);
        repeat (10) @(negedge clk);
        chk("t3_no_extra", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_stream_ctrl.md
Name: lcd_stream_ctrl

Overview:
- Parametrised HD44780-class character LCD driver, 8-bit bus, write-only.
- Runs its own power-up wait and init command sequence, then drains a byte FIFO fed by a valid/ready stream. Each entry is one {RS, data} pair.
- Per-byte EN pulse width and settle time are parameters. The settle time is chosen automatically: short for normal bytes, long for clear/home commands.
- Sits between the CPU display/format logic and the LCD pins, replacing fixed per-instruction delay counters in the formatters.

Parameters:
- EN_CYC, 50: lcd_en high time in clk cycles (1 us @ 50 MHz); >=1.
- SHORT_CYC, 2500: settle cycles after a normal byte (50 us); >=1.
- LONG_CYC, 100000: settle cycles after clear/home commands (2 ms); >=1.
- PWRUP_CYC, 1000000: wait after reset release before the first command (20 ms); >=1.
- FIFO_DEPTH, 4: input FIFO entries; power of two, >=2.
- TWO_LINE, 1: 1 -> function set 0x38; 0 -> 0x30.
- DISP_CMD, 8'h0E: display-control byte sent during init (display on, cursor on).

Ports:
- clk in 1: system clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- in_valid in 1: stream byte valid.
- in_ready out 1: FIFO can accept; combinational !full.
- in_rs in 1: 0 = command, 1 = character data.
- in_data in 8: byte to write.
- init_done out 1: init sequence finished; stays high until reset.
- busy out 1: high when state != IDLE or the FIFO is non-empty.
- lcd_en out 1: LCD enable strobe.
- lcd_rw out 1: LCD read/write; tied 0.
- lcd_rs out 1: LCD register select.
- lcd_data out 8: LCD data bus.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=0, init_done=0, busy=1.
  - FIFO emptied, so in_ready=1. Counters cleared; state=PWRUP.
  - Reset asserted mid-pulse or mid-wait aborts immediately; after release the full PWRUP + init sequence repeats.
- Push rule: a byte is accepted on a rising edge with in_valid && in_ready. Pushes are accepted during PWRUP/init and held until init_done.
- No pass-through:
  - When the FIFO is full, a same-cycle pop does not allow a push (in_ready=0 that cycle).
  - When the FIFO is empty, a pushed byte is not popped in the same cycle.
- State machine: PWRUP, IDLE, SETUP, PULSE, SETTLE.
- PWRUP:
  - Counts PWRUP_CYC cycles with lcd_en=0.
  - Then loads init index 0 and goes to SETUP.
  - Init list, all RS=0, in order: FSET, FSET, DISP_CMD, 0x01, 0x06. FSET = 0x38 if TWO_LINE, else 0x30.
- SETUP:
  - 1 cycle. lcd_rs/lcd_data are already registered (loaded on entry edge); lcd_en=0.
  - Next state PULSE.
- PULSE: lcd_en=1 for exactly EN_CYC cycles; RS/data held stable. Next state SETTLE.
- SETTLE:
  - lcd_en=0; RS/data held.
  - Waits LONG_CYC cycles if the byte was a command with data[7:2]==0 (0x01-0x03); otherwise SHORT_CYC.
  - Exit during init: if init index < 4, increment index and load the next init byte -> SETUP. After init byte 4, set init_done=1 -> IDLE.
  - Exit after init: go to IDLE.
- IDLE:
  - If init_done and FIFO non-empty: pop head, register lcd_rs/lcd_data, go to SETUP. Otherwise stay; lcd_en=0.
- Per-byte period from the IDLE pop edge to the next IDLE: 1 + 1 + EN_CYC + settle cycles.
- FIFO ordering is strict first-in, first-out.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full/empty come from MSB and index compare.
- Counter width is sized for the largest of PWRUP_CYC, LONG_CYC, SHORT_CYC, EN_CYC. Counter resets to 0 on each state entry.

Test Plan:
Bench parameters: EN_CYC=2, SHORT_CYC=4, LONG_CYC=10, PWRUP_CYC=20, FIFO_DEPTH=4.
1. Release reset, no stream input:
   - No lcd_en for the first 20 cycles.
   - Then exactly 5 lcd_en pulses, each 2 cycles high, sampling 0x38, 0x38, 0x0E, 0x01, 0x06 with RS=0.
   - Gap after the 0x01 pulse is 10 cycles, after the others 4.
   - init_done rises after the 5th settle.
2. After init_done, push {RS=1, 0x41}:
   - lcd_data=0x41, lcd_rs=1 one cycle before lcd_en rises.
   - lcd_en high 2 cycles; busy drops 4 settle cycles later plus the IDLE cycle.
3. Push 6 bytes back-to-back during PWRUP:
   - in_ready drops after 4 accepted.
   - After init, exactly 4 bytes appear on the bus in push order.
4. Push command 0x02 then char 0x42: settle after 0x02 is 10 cycles, after 0x42 is 4.
5. Assert rst_n low while lcd_en=1 mid-pulse:
   - lcd_en/lcd_data/init_done go to 0 asynchronously; FIFO empty; in_ready=1.
   - After release, the full 20-cycle PWRUP and init sequence repeat.
6. Rebuild with TWO_LINE=0: first two init bytes are 0x30.
